// File: rtl/vga_mode_sequencer_if.sv
// Control/status bundle between the frame timing logic and the mode sequencer.
// The sequencer side uses the slave modport; the master side drives frame_start and the buttons.
interface vga_mode_sequencer_if;
    logic       frame_start;
    logic       btn_next;
    logic       btn_hold;
    logic [2:0] inymode;
    logic       mixnoise;
    logic       usewobble;
    logic       auto_run;
    logic       mode_change;

    modport master (
        output frame_start, btn_next, btn_hold,
        input  inymode, mixnoise, usewobble, auto_run, mode_change
    );

    modport slave (
        input  frame_start, btn_next, btn_hold,
        output inymode, mixnoise, usewobble, auto_run, mode_change
    );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Steps the pattern mode on a frame timer or debounced button presses.
// Define MODE_SEQ_WOBBLE_EN to extend the mode range to 0..31 and drive usewobble.
module vga_mode_sequencer #(
    parameter int unsigned FRAMES_PER_MODE = 120,
    parameter logic [4:0]  INIT_MODE       = 5'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_mode_sequencer_if.slave  seq
);
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned MODE_W = 5;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(FRAMES_PER_MODE - 1);
`ifdef MODE_SEQ_WOBBLE_EN
    localparam logic [MODE_W-1:0] MODE_MASK = 5'h1f;
`else
    localparam logic [MODE_W-1:0] MODE_MASK = 5'h0f;
`endif
    localparam logic [MODE_W-1:0] RESET_MODE = INIT_MODE & MODE_MASK;

    typedef enum logic {
        AUTO   = 1'b0,
        PAUSED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic                mode_change_q, mode_change_d;
    logic [1:0]          next_sync_q, hold_sync_q;
    logic [1:0]          next_hist_q, next_hist_d;
    logic [1:0]          hold_hist_q, hold_hist_d;
    logic                next_press, hold_press, terminal, advance;

    // Synchronizers run every cycle; everything else only moves on frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_sync_q   <= 2'b00;
            hold_sync_q   <= 2'b00;
            state_q       <= AUTO;
            cnt_q         <= '0;
            mode_q        <= RESET_MODE;
            mode_change_q <= 1'b0;
            next_hist_q   <= 2'b00;
            hold_hist_q   <= 2'b00;
        end else begin
            next_sync_q   <= {next_sync_q[0], seq.btn_next};
            hold_sync_q   <= {hold_sync_q[0], seq.btn_hold};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            mode_change_q <= mode_change_d;
            next_hist_q   <= next_hist_d;
            hold_hist_q   <= hold_hist_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        mode_change_d = 1'b0;
        next_hist_d   = next_hist_q;
        hold_hist_d   = hold_hist_q;
        next_press    = 1'b0;
        hold_press    = 1'b0;
        terminal      = 1'b0;
        advance       = 1'b0;

        if (seq.frame_start) begin
            // A press is low-high-high across three consecutive frame samples.
            next_press  = ({next_hist_q, next_sync_q[1]} == 3'b011);
            hold_press  = ({hold_hist_q, hold_sync_q[1]} == 3'b011);
            next_hist_d = {next_hist_q[0], next_sync_q[1]};
            hold_hist_d = {hold_hist_q[0], hold_sync_q[1]};

            terminal = (state_q == AUTO) && (cnt_q == TERM_CNT);
            advance  = next_press || terminal;

            if (hold_press) begin
                state_d = (state_q == AUTO) ? PAUSED : AUTO;
            end

            if (advance) begin
                mode_d        = (mode_q + 5'd1) & MODE_MASK;
                cnt_d         = '0;
                mode_change_d = 1'b1;
            end else if (state_q == AUTO) begin
                cnt_d = cnt_q + 10'd1;
            end

            // Paused keeps the counter parked so resuming starts a full period.
            if (state_d == PAUSED) begin
                cnt_d = '0;
            end
        end
    end

    assign seq.inymode     = mode_q[2:0];
    assign seq.mixnoise    = mode_q[3];
`ifdef MODE_SEQ_WOBBLE_EN
    assign seq.usewobble   = mode_q[4];
`else
    assign seq.usewobble   = 1'b0;
`endif
    assign seq.auto_run    = (state_q == AUTO);
    assign seq.mode_change = mode_change_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Scoreboard bench for vga_mode_sequencer: a frame-level model queues expected modes,
// a negedge monitor checks each mode_change pulse and flags unannounced output changes.
module tb_vga_mode_sequencer;
    localparam int unsigned FPM = 4;
`ifdef MODE_SEQ_WOBBLE_EN
    localparam int MODES = 32;
`else
    localparam int MODES = 16;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_mode_sequencer_if bus();

    vga_mode_sequencer #(
        .FRAMES_PER_MODE(FPM),
        .INIT_MODE      (5'd0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .seq  (bus)
    );

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    // Frame-level reference state
    int m_mode;
    int m_cnt;
    bit m_auto;
    bit m_n1, m_n2, m_h1, m_h2;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_mode();
        logic [4:0] v;
        v = {bus.usewobble, bus.mixnoise, bus.inymode};
        return int'(v);
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_auto = 1'b1;
        m_n1 = 1'b0; m_n2 = 1'b0; m_h1 = 1'b0; m_h2 = 1'b0;
        exp_q.delete();
    endtask

    // One frame_start as seen from the outside: buttons sampled, presses judged, timer stepped.
    task automatic model_step(input bit bn, input bit bh);
        bit pn, ph, adv;
        pn = !m_n2 && m_n1 && bn;
        ph = !m_h2 && m_h1 && bh;
        m_n2 = m_n1; m_n1 = bn;
        m_h2 = m_h1; m_h1 = bh;
        adv = pn || (m_auto && (m_cnt == FPM - 1));
        if (adv) begin
            m_mode = (m_mode + 1) % MODES;
            m_cnt  = 0;
            exp_q.push_back(m_mode);
        end else if (m_auto) begin
            m_cnt++;
        end
        if (ph) m_auto = !m_auto;
        if (!m_auto) m_cnt = 0;
    endtask

    // Monitor: every mode_change must match the queue head; outputs may not move otherwise.
    int last_mode = 0;
    always @(negedge clk) begin
        if (reset) begin
            last_mode = cur_mode();
        end else if (bus.mode_change) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mode_change: unexpected pulse, mode %0d at %0t", cur_mode(), $time);
            end else begin
                check("mode_idx", cur_mode(), exp_q.pop_front());
            end
            last_mode = cur_mode();
        end else begin
            check("mode_stable", cur_mode(), last_mode);
        end
    end

    // One 16-cycle frame: buttons set early, optional mid-frame glitch on btn_next, then frame_start.
    task automatic frame(input bit bn, input bit bh, input bit glitch);
        @(posedge clk); #1;
        bus.btn_next = bn;
        bus.btn_hold = bh;
        repeat (4) @(posedge clk);
        #1;
        if (glitch) bus.btn_next = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (glitch) bus.btn_next = bn;
        repeat (7) @(posedge clk);
        #1;
        bus.frame_start = 1'b1;
        model_step(bn, bh);
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        @(negedge clk);
        check("auto_run", int'(bus.auto_run), int'(m_auto));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.btn_next = 1'b0;
        bus.btn_hold = 1'b0;
        bus.frame_start = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_hold = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_inymode", int'(bus.inymode), 0);
        check("rst_mixnoise", int'(bus.mixnoise), 0);
        check("rst_usewobble", int'(bus.usewobble), 0);
        check("rst_auto_run", int'(bus.auto_run), 1);
        check("rst_mode_change", int'(bus.mode_change), 0);

        // Auto-run through a full wrap
        for (int i = 0; i < MODES * FPM + 2; i++) frame(1'b0, 1'b0, 1'b0);

        // Pause, then hold btn_next for 10 frames, release, re-press for 2
        do_reset();
        frame(1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b1, 1'b0);
        check("paused", int'(bus.auto_run), 0);
        frame(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) frame(1'b1, 1'b0, 1'b0);
        check("held_once", cur_mode(), 1);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        check("repress", cur_mode(), 2);

        // Glitches: single-frame high, and high only between frame_starts
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) frame(1'b0, 1'b0, 1'b0);
        check("glitch_none", cur_mode(), 2);

        // Resume; next auto advance four frames after the toggle
        frame(1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b1, 1'b0);
        check("resumed", int'(bus.auto_run), 1);
        for (int i = 0; i < 6; i++) frame(1'b0, 1'b0, 1'b0);

        // Collision: btn_next accepted on the terminal-count frame
        do_reset();
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        check("collision", cur_mode(), 1);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        check("collision_cnt", cur_mode(), 1);
        frame(1'b0, 1'b0, 1'b0);
        check("collision_next", cur_mode(), 2);

        // Randomized button traffic
        for (int i = 0; i < 200; i++) begin
            frame(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0));
        end

        // Reset coinciding with frame_start while mode is 5
        do_reset();
        for (int i = 0; i < 5 * FPM; i++) frame(1'b0, 1'b0, 1'b0);
        check("pre_reset_mode", cur_mode(), 5);
        @(posedge clk); #1;
        bus.frame_start = 1'b1;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        @(negedge clk);
        check("rst_mid_mode", cur_mode(), 0);
        check("rst_mid_auto_run", int'(bus.auto_run), 1);
        check("rst_mid_mode_change", int'(bus.mode_change), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < FPM + 1; i++) frame(1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_mode_sequencer.md
VGA_MODE_SEQUENCER -- requirements
Module: vga_mode_sequencer

Interface
REQ-001 SHALL have parameter FRAMES_PER_MODE, default 120: frames per mode in auto-run (legal range 1..1023).
REQ-002 SHALL have parameter INIT_MODE, default 0: 5-bit mode index loaded at reset.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse at start of each frame (hpos==0 and vpos==0).
REQ-006 SHALL have port btn_next  input  1  raw asynchronous "next mode" button, active-high.
REQ-007 SHALL have port btn_hold  input  1  raw asynchronous "pause/resume auto-run" button, active-high.
REQ-008 SHALL have port inymode  output  3  mode select to the pattern datapath.
REQ-009 SHALL have port mixnoise  output  1  noise-mix enable to the pattern datapath.
REQ-010 SHALL have port usewobble  output  1  wobble enable to the pattern datapath.
REQ-011 SHALL have port auto_run  output  1  high in AUTO state.
REQ-012 SHALL have port mode_change  output  1  one-cycle pulse, coincident with the first cycle new mode outputs are valid.

Function
REQ-013 SHALL hold a 5-bit mode_idx; inymode=mode_idx[2:0], mixnoise=mode_idx[3], usewobble=mode_idx[4]; all outputs registered.
REQ-014 SHALL pass btn_next and btn_hold through 2-flop synchronizers before use.
REQ-015 SHALL sample each synchronized button only on cycles with frame_start=1, shifting the sample into a 2-bit per-button history.
REQ-016 SHALL accept a press when {history[1], history[0], current sample} == 3'b011: high on two consecutive frame samples after a low one. A held button yields exactly one press. A one-frame high yields none.
REQ-017 SHALL implement states AUTO and PAUSED. An accepted btn_hold press toggles AUTO<->PAUSED on that frame_start cycle.
REQ-018 In AUTO, the frame counter (10 bits) SHALL increment on each frame_start. When it equals FRAMES_PER_MODE-1 on a frame_start, the block SHALL advance mode_idx by 1 and clear the counter.
REQ-019 In PAUSED, the frame counter SHALL be held at 0.
REQ-020 An accepted btn_next press SHALL advance mode_idx by 1 and clear the frame counter, in either state.
REQ-021 If auto terminal count and an accepted btn_next occur on the same frame_start, mode_idx SHALL advance by exactly 1.
REQ-022 Entering AUTO from PAUSED SHALL start counting from 0.
REQ-023 mode_idx, outputs and state SHALL change only on the clock edge where frame_start=1. New values SHALL be valid the following cycle, and mode_change SHALL be 1 for exactly that cycle.
REQ-024 mode_idx SHALL wrap from its maximum value to 0 (see Configuration).
REQ-025 frame_start=0 cycles SHALL leave all state unchanged except the synchronizer flops.

Reset
REQ-026 On reset, the following SHALL be loaded:
- mode_idx=INIT_MODE
- state=AUTO, auto_run=1
- frame counter=0
- histories=0, synchronizers=0
- mode_change=0
REQ-027 Reset asserted mid-operation SHALL take effect on the next clock edge, overriding frame_start and button activity.

Configuration
REQ-028 Macro MODE_SEQ_WOBBLE_EN defined: mode_idx SHALL span 0..31 (wrap 31->0), and usewobble=mode_idx[4].
REQ-029 Macro MODE_SEQ_WOBBLE_EN undefined:
- mode_idx[4] SHALL be forced to 0, so mode_idx spans 0..15 (wrap 15->0).
- usewobble SHALL be constant 0.
- INIT_MODE[4] SHALL be ignored.

Verification (FRAMES_PER_MODE=4, INIT_MODE=0, frame_start every 16 cycles)
REQ-030 Auto-run test: reset, no buttons -> mode_idx 0->1 after the 4th frame_start, 1->2 after the 8th; mode_change pulses once per advance. With MODE_SEQ_WOBBLE_EN, 32 advances return to 0 with usewobble high for idx 16..31; without it, 16 advances return to 0 with usewobble always 0.
REQ-031 Held button test: btn_next high across frame_starts 1..10 (counter held in PAUSED) -> exactly one advance, at frame_start 2; released then re-pressed for 2 frames -> one more advance.
REQ-032 Glitch test: btn_next high for a single frame_start sample, or high only between frame_starts -> no advance.
REQ-033 Hold test: btn_hold pressed for 2 frames -> auto_run 0; 20 further frames -> mode_idx unchanged; second btn_hold press -> auto_run 1, next advance after 4 more frame_starts.
REQ-034 Collision test: btn_next acceptance coincides with auto terminal count -> mode_idx +1 only, counter 0, single mode_change pulse.
REQ-035 Reset test: reset during mode_idx=5 with frame_start=1 on the same cycle -> next cycle mode_idx=0, auto_run=1, mode_change=0.
